// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// keypad_scan : key-matrix scanner, debouncer and press/release event FIFO
// Revision    : 1.0
// ============================================================================
module keypad_scan #(
  parameter int BASE       = 1 << 5,
  parameter int SIZE       = 2,
  parameter int NROWS      = 4,
  parameter int NCOLS      = 4,
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rw,
  input  logic [31:0]      addr,
  inout  wire  [31:0]      data,
  output logic [NCOLS-1:0] col,
  input  logic [NROWS-1:0] row
);

  localparam int c_nkeys = NROWS * NCOLS;
  localparam int c_cw    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int c_dw    = $clog2(SCAN_DIV);
  localparam int c_sw    = $clog2(DEBOUNCE + 1);
  localparam int c_aw    = $clog2(FIFO_DEPTH);

  logic [NROWS-1:0]   row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [c_dw-1:0]    div_q, div_d;
  logic [c_cw-1:0]    col_idx_q, col_idx_d;
  logic [c_nkeys-1:0] raw_q, raw_d, prev_q, prev_d, state_q, state_d;
  logic [c_sw-1:0]    stable_q, stable_d;
  logic [c_aw:0]      wr_q, wr_d, rd_q, rd_d;
  logic               ovf_q, ovf_d;
  logic [8:0]         mem_q [FIFO_DEPTH];
  logic [8:0]         mem_d [FIFO_DEPTH];

  logic               last_cycle, scan_done;
  logic [31:0]        sel_off;
  logic               in_range, rd_state, rd_event, wr_event, bus_drive;
  logic               fifo_empty, fifo_full, pop, push;
  logic [c_nkeys-1:0] diff, lsb;
  logic [7:0]         key_idx;
  logic [8:0]         ev;
  logic [31:0]        ev_word, rd_data;

  assign last_cycle = (div_q == c_dw'(SCAN_DIV - 1));
  assign scan_done  = last_cycle && (col_idx_q == c_cw'(NCOLS - 1));

  assign sel_off   = addr - 32'(BASE);
  assign in_range  = (addr >= 32'(BASE)) && (addr < 32'(BASE + SIZE));
  assign rd_state  = enable && !rw && in_range && (sel_off == 32'd0);
  assign rd_event  = enable && !rw && in_range && (sel_off == 32'd1);
  assign wr_event  = enable &&  rw && in_range && (sel_off == 32'd1);
  assign bus_drive = enable && !rw && in_range;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[c_aw] != rd_q[c_aw]) && (wr_q[c_aw-1:0] == rd_q[c_aw-1:0]);

  always_comb begin
    for (int c = 0; c < NCOLS; c++) begin
      col[c] = !(int'(col_idx_q) == c);
    end
  end

  // Scan timing and raw capture; the raw seen at completion already holds the last column.
  always_comb begin
    row_s1_d  = row;
    row_s2_d  = row_s1_q;
    div_d     = div_q + c_dw'(1);
    col_idx_d = col_idx_q;
    raw_d     = raw_q;
    if (last_cycle) begin
      div_d     = '0;
      col_idx_d = (col_idx_q == c_cw'(NCOLS - 1)) ? '0 : col_idx_q + c_cw'(1);
      for (int r = 0; r < NROWS; r++) begin
        for (int c = 0; c < NCOLS; c++) begin
          if (int'(col_idx_q) == c) raw_d[r*NCOLS+c] = !row_s2_q[r];
        end
      end
    end
  end

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    state_d  = state_q;
    diff     = raw_d ^ state_q;
    lsb      = diff & (~diff + c_nkeys'(1));
    key_idx  = '0;
    push     = 1'b0;
    for (int i = 0; i < c_nkeys; i++) begin
      if (lsb[i]) key_idx = 8'(i);
    end
    ev = {|(raw_d & lsb), key_idx};
    if (scan_done) begin
      prev_d = raw_d;
      if (raw_d != prev_q)                  stable_d = '0;
      else if (stable_q < c_sw'(DEBOUNCE)) stable_d = stable_q + c_sw'(1);
      // One key per scan, lowest index first, so simultaneous changes queue in order.
      if ((stable_d >= c_sw'(DEBOUNCE)) && (diff != '0)) begin
        state_d = (state_q & ~lsb) | (raw_d & lsb);
        push    = 1'b1;
      end
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    mem_d = mem_q;
    pop   = rd_event && !fifo_empty;
    if (wr_event) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop) rd_d = rd_q + (c_aw+1)'(1);
      if (push) begin
        if (fifo_full && !pop) begin
          ovf_d = 1'b1;
        end else begin
          mem_d[wr_q[c_aw-1:0]] = ev;
          wr_d = wr_q + (c_aw+1)'(1);
        end
      end
    end
  end

  always_comb begin
    if (fifo_empty) ev_word = {1'b0, ovf_q, 30'b0};
    else            ev_word = {1'b1, ovf_q, 21'b0, mem_q[rd_q[c_aw-1:0]]};
    rd_data = rd_state ? 32'(state_q) : ev_word;
  end

  assign data = bus_drive ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q  <= '1;
      row_s2_q  <= '1;
      div_q     <= '0;
      col_idx_q <= '0;
      raw_q     <= '0;
      prev_q    <= '0;
      state_q   <= '0;
      stable_q  <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      row_s1_q  <= row_s1_d;
      row_s2_q  <= row_s2_d;
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      stable_q  <= stable_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// tb_keypad_scan : randomized scan-level reference model bench for keypad_scan
// Revision       : 1.0
// ============================================================================
module tb_keypad_scan;

  localparam int BASE       = 1 << 5;
  localparam int NROWS      = 4;
  localparam int NCOLS      = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NKEYS      = NROWS * NCOLS;
  localparam int P          = SCAN_DIV * NCOLS;

  localparam int OP_IDLE = 0, OP_RD_STATE = 1, OP_RD_EVENT = 2,
                 OP_FLUSH = 3, OP_WR_STATE = 4, OP_RD_OOR = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             rw;
  logic [31:0]      addr;
  wire  [31:0]      data;
  logic [NCOLS-1:0] col;
  logic [NROWS-1:0] row;
  logic [NKEYS-1:0] keys;

  int n_checks = 0;
  int n_errors = 0;
  int op_plan [P];

  // Scan-level reference model: one debounce step per full scan of held keys.
  logic [NKEYS-1:0] m_prev, m_state;
  int               m_cnt;
  logic             m_ovf;
  logic [8:0]       q [$];

  keypad_scan dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .rw     (rw),
    .addr   (addr),
    .data   (data),
    .col    (col),
    .row    (row)
  );

  always #5 clk = ~clk;

  // Ideal key matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = '1;
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOLS; c++)
        if (keys[r*NCOLS+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = '0;
    m_state = '0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    q.delete();
  endtask

  task automatic model_scan(input logic [NKEYS-1:0] k, input bit flush_edge);
    logic [NKEYS-1:0] d;
    int idx;
    if (k != m_prev) m_cnt = 0;
    else if (m_cnt < DEBOUNCE) m_cnt++;
    m_prev = k;
    d = k ^ m_state;
    if (m_cnt >= DEBOUNCE && d != '0) begin
      idx = 0;
      while (!d[idx]) idx++;
      m_state[idx] = k[idx];
      if (!flush_edge) begin
        if (q.size() < FIFO_DEPTH) q.push_back({k[idx], 8'(idx)});
        else m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_ev();
    if (q.size() == 0) return {1'b0, m_ovf, 30'b0};
    return {1'b1, m_ovf, 21'b0, q[0]};
  endfunction

  task automatic plan_clear();
    for (int i = 0; i < P; i++) op_plan[i] = OP_IDLE;
  endtask

  // One full scan with keys held; called at the negedge just after a scan boundary.
  task automatic do_scan(input logic [NKEYS-1:0] k, input int rst_at);
    bit fl_last;
    logic [NCOLS-1:0] ec;
    fl_last = 1'b0;
    keys = k;
    for (int i = 0; i < P; i++) begin
      ec = '1;
      ec[i / SCAN_DIV] = 1'b0;
      check("col", 32'(col), 32'(ec));
      if (i == rst_at) begin
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        plan_clear();
        return;
      end
      enable = 1'b0;
      rw     = 1'($urandom_range(0, 1));
      addr   = $urandom;
      case (op_plan[i])
        OP_RD_STATE: begin enable = 1'b1; rw = 1'b0; addr = BASE;     end
        OP_RD_EVENT: begin enable = 1'b1; rw = 1'b0; addr = BASE + 1; end
        OP_FLUSH:    begin enable = 1'b1; rw = 1'b1; addr = BASE + 1; end
        OP_WR_STATE: begin enable = 1'b1; rw = 1'b1; addr = BASE;     end
        OP_RD_OOR:   begin
          enable = 1'b1; rw = 1'b0;
          addr = ($urandom_range(0, 1) == 1) ? BASE - 1 : BASE + 2 + $urandom_range(0, 100);
        end
        default: ;
      endcase
      #1;
      case (op_plan[i])
        OP_IDLE:     if (i % SCAN_DIV == 1) check("idle_z", data, 'z);
        OP_RD_STATE: check("state", data, 32'(m_state));
        OP_RD_EVENT: begin
          check("event", data, exp_ev());
          if (q.size() > 0) void'(q.pop_front());
        end
        OP_FLUSH: begin
          q.delete();
          m_ovf = 1'b0;
          if (i == P - 1) fl_last = 1'b1;
        end
        OP_RD_OOR:   check("oor_z", data, 'z);
        default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
    end
    enable = 1'b0;
    plan_clear();
    model_scan(k, fl_last);
  endtask

  task automatic scans(input logic [NKEYS-1:0] k, input int n);
    repeat (n) do_scan(k, -1);
  endtask

  logic [NKEYS-1:0] kk, rk;
  int hold, rst_at;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    rw     = 1'b0;
    addr   = '0;
    keys   = '0;
    plan_clear();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and column rotation
    op_plan[0] = OP_RD_STATE; op_plan[1] = OP_RD_EVENT; op_plan[2] = OP_RD_OOR;
    do_scan('0, -1);

    // Single key r1,c2 press then release
    scans(16'h0040, 3);
    op_plan[0] = OP_RD_STATE; op_plan[1] = OP_RD_EVENT; op_plan[2] = OP_RD_EVENT;
    do_scan(16'h0040, -1);
    scans('0, 3);
    op_plan[0] = OP_RD_EVENT; op_plan[1] = OP_RD_STATE;
    do_scan('0, -1);

    // One-scan glitch on key 0 must not commit
    scans(16'h0001, 1);
    scans('0, 3);
    op_plan[0] = OP_RD_STATE; op_plan[1] = OP_RD_EVENT; op_plan[3] = OP_WR_STATE;
    do_scan('0, -1);

    // Keys 3 and 9 together commit in ascending order
    scans(16'h0208, 4);
    op_plan[0] = OP_RD_STATE; op_plan[1] = OP_RD_EVENT;
    op_plan[2] = OP_RD_EVENT; op_plan[3] = OP_RD_EVENT;
    do_scan(16'h0208, -1);
    scans('0, 4);
    op_plan[0] = OP_FLUSH; op_plan[1] = OP_RD_EVENT;
    do_scan('0, -1);

    // FIFO fill, pop+push on a full FIFO, overflow, flush
    kk = '0;
    for (int e = 0; e < 4; e++) begin kk ^= 16'h0002; scans(kk, 3); end
    kk ^= 16'h0002; scans(kk, 2);
    op_plan[P-1] = OP_RD_EVENT;
    do_scan(kk, -1);
    op_plan[0] = OP_RD_EVENT;
    do_scan(kk, -1);
    for (int e = 0; e < 2; e++) begin kk ^= 16'h0002; scans(kk, 3); end
    op_plan[0] = OP_RD_EVENT; op_plan[2] = OP_FLUSH;
    op_plan[4] = OP_RD_EVENT; op_plan[6] = OP_RD_STATE;
    do_scan(kk, -1);

    // Flush on the commit edge wins; pop on an empty FIFO keeps the push
    kk ^= 16'h0002; scans(kk, 2);
    op_plan[P-1] = OP_FLUSH;
    do_scan(kk, -1);
    op_plan[0] = OP_RD_EVENT; op_plan[1] = OP_RD_STATE;
    do_scan(kk, -1);
    kk ^= 16'h0002; scans(kk, 2);
    op_plan[P-1] = OP_RD_EVENT;
    do_scan(kk, -1);
    op_plan[0] = OP_RD_EVENT; op_plan[1] = OP_RD_EVENT;
    do_scan(kk, -1);
    scans('0, 3);
    op_plan[0] = OP_FLUSH;
    do_scan('0, -1);

    // Reset with two queued events and a half-debounced key
    scans(16'h0020, 3);
    scans('0, 3);
    scans(16'h0080, 2);
    do_scan(16'h0080, 7);
    op_plan[0] = OP_RD_STATE; op_plan[1] = OP_RD_EVENT;
    do_scan(16'h0080, -1);
    scans(16'h0080, 1);
    op_plan[0] = OP_RD_STATE; op_plan[1] = OP_RD_EVENT;
    op_plan[P-1] = OP_RD_STATE;
    do_scan(16'h0080, -1);
    op_plan[0] = OP_RD_EVENT; op_plan[1] = OP_RD_STATE;
    do_scan(16'h0080, -1);

    // Randomized key patterns and bus traffic
    rk = 16'h0080;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: rk = '0;
        1: rk = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
        2: rk = (NKEYS'(1) << $urandom_range(0, NKEYS - 1)) |
                (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
        default: ;
      endcase
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        for (int i = 0; i < P; i++)
          if ($urandom_range(0, 5) == 0) op_plan[i] = $urandom_range(1, 5);
        rst_at = ($urandom_range(0, 40) == 0) ? $urandom_range(0, P - 1) : -1;
        do_scan(rk, rst_at);
      end
    end
    op_plan[0] = OP_RD_STATE;
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) op_plan[i] = OP_RD_EVENT;
    do_scan(rk, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Memory-mapped input peripheral; the reading counterpart to the multiplexed 7-segment display driver.
- Time-multiplexes a NROWS x NCOLS key matrix by driving one column low at a time and sampling the rows.
- Debounces the key matrix, keeps a debounced key bitmap and queues press/release events in a small FIFO.
- The CPU reads both over the shared enable/rw/addr/data bus.

Parameters:
BASE, 1 << 5, first bus word address of the block
SIZE, 2, number of word addresses decoded (BASE+0 state, BASE+1 event)
NROWS, 4, matrix rows (NROWS*NCOLS <= 32)
NCOLS, 4, matrix columns
SCAN_DIV, 4, clk cycles each column is held active (>= 3)
DEBOUNCE, 2, consecutive identical full scans required before commit
FIFO_DEPTH, 4, event FIFO entries (power of two)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  bus cycle valid
rw  input  1  1 = write, 0 = read
addr  input  32  word address
data  inout  32  bus data; driven only during an in-range read, else high-Z
col  output  NCOLS  column drive, active-low one-hot
row  input  NROWS  row sense, active-low (pulled up externally), asynchronous

Behaviour:
- Reset (synchronous): col = ~1 (column 0 active), scan counters 0, raw/prev bitmaps 0, stable count 0, state bitmap 0, FIFO empty, overflow 0, data high-Z.
- in_range = addr >= BASE && addr < BASE+SIZE.
- Row input: 2-FF synchronizer, then inverted, so 1 = pressed.
- Scan:
  - Column c is held SCAN_DIV cycles, then rotates c -> c+1 mod NCOLS.
  - On the last cycle of column c, the synchronized rows are written to raw[r*NCOLS+c] for every r.
  - A full scan takes P = SCAN_DIV*NCOLS cycles; scan completion is the last cycle of column NCOLS-1.
- Debounce, evaluated at each scan completion on the just-completed raw:
  - raw != prev: stable count = 0.
  - raw == prev: stable count += 1, saturating at DEBOUNCE.
  - prev <= raw.
  - If count (post-update) >= DEBOUNCE and raw != state: commit only the lowest-index differing bit k. Set state[k] = raw[k] and push event {press = raw[k], index = k}.
  - Remaining differing bits commit one per subsequent scan, ascending index.
- Event word format: bit31 = FIFO non-empty, bit30 = overflow (sticky), bit8 = press(1)/release(0), bits7:0 = key index. Bits 29:9 are 0.
- Read BASE+0 (enable & !rw): data = state bitmap zero-extended, combinational. No side effects.
- Read BASE+1:
  - data = head event word, combinational.
  - When the FIFO is empty, data = {1'b0, overflow, 30'b0}.
  - The rising edge with the read asserted pops the head if non-empty. A bus master holds enable for one cycle per read.
- Write BASE+1 (enable & rw): flushes the FIFO and clears overflow on that edge; data value ignored.
- Write BASE+0: ignored.
- FIFO full + push, no pop: event dropped, overflow <= 1, state bitmap still updated.
- FIFO full + push + pop same edge: pop then push; no overflow.
- FIFO empty + push + pop same edge: read returns empty word; push retained.
- Flush + push same edge: flush wins; FIFO ends empty and overflow ends 0.
- Reset mid-scan or with a pending event: everything returns to reset values on that edge; no event emitted.

Test Plan:
All cases use defaults; P = 16 cycles.

1. Reset, idle rows all 1 -> col = 4'b1110, rotates every 4 cycles (1101, 1011, 0111, 1110). Read BASE+0 = 0x00000000; read BASE+1 = 0x00000000.
2. Key r1,c2 held low from before scan k -> commit at end of third scan containing the press. BASE+0 = 0x00000040; BASE+1 = 0x80000106, popped; next read = 0x00000000. Release later -> event 0x80000006.
3. Key r0,c0 low for exactly one scan window, then released -> no event, BASE+0 stays 0.
4. Keys 3 and 9 pressed together -> 0x80000103 committed one scan before 0x80000109; final BASE+0 = 0x00000208.
5. Five events with no reads -> first four retained in order. Head read = 0xC00001xx (bit30 set). Write BASE+1 -> read returns 0x00000000.
6. Assert reset while FIFO holds 2 events and the stable count is mid-way -> col = 1110, BASE+0 = 0, BASE+1 = 0, and held keys re-commit after the full debounce from scratch.
